// File: rtl/shift_seq_ctrl.sv
// Start/busy/done sequencer driving one 4-bit universal shift register: load, shift N, capture.
// Optional ROTATE_EN macro adds a rotate input that feeds the register's own end bit back in.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic             fill,
    input  logic [WIDTH-1:0] data_in,
`ifdef ROTATE_EN
    input  logic             rotate,
`endif
    input  logic [WIDTH-1:0] a_par,
    output logic             s1,
    output logic             s0,
    output logic             msb_in,
    output logic             lsb_in,
    output logic [WIDTH-1:0] i_par,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_n;
    logic             r_dir;
    logic             r_fill;
    logic             r_rot;
    logic [WIDTH-1:0] r_ipar;
    logic [WIDTH-1:0] r_result;
    logic             w_fill_r;
    logic             w_fill_l;

    // n never exceeds amount, so it always fits in the amount field width.
    assign w_n = (int'(amount) > WIDTH) ? CNT_W'(WIDTH) : amount;

`ifdef ROTATE_EN
    assign w_fill_r = r_rot ? a_par[0]       : r_fill;
    assign w_fill_l = r_rot ? a_par[WIDTH-1] : r_fill;
`else
    assign w_fill_r = r_fill;
    assign w_fill_l = r_fill;
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_d = ST_LOAD;
            ST_LOAD:    w_state_d = (r_cnt != '0) ? ST_SHIFT : ST_CAPTURE;
            ST_SHIFT:   if (r_cnt == CNT_W'(1)) w_state_d = ST_CAPTURE;
            ST_CAPTURE: w_state_d = ST_DONE;
            ST_DONE:    w_state_d = ST_IDLE;
            default:    w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_fill   <= 1'b0;
            r_rot    <= 1'b0;
            r_ipar   <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == ST_IDLE && start) begin
                r_ipar <= data_in;
                r_dir  <= dir;
                r_fill <= fill;
                r_cnt  <= w_n;
`ifdef ROTATE_EN
                r_rot  <= rotate;
`endif
            end
            if (r_state == ST_SHIFT) r_cnt <= r_cnt - CNT_W'(1);
            if (r_state == ST_CAPTURE) r_result <= a_par;
        end
    end

    always_comb begin
        s1     = 1'b0;
        s0     = 1'b0;
        msb_in = 1'b0;
        lsb_in = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                s1   = 1'b1;
                s0   = 1'b1;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                s1     = r_dir;
                s0     = ~r_dir;
                msb_in = ~r_dir & w_fill_r;
                lsb_in = r_dir & w_fill_l;
                busy   = 1'b1;
            end
            ST_CAPTURE: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign i_par  = r_ipar;
    assign result = r_result;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: drives a behavioural 4-bit shift register from the DUT's controls and
// checks per-cycle controls and captured results against a shift/rotate reference model.
module tb_shift_seq_ctrl;

    logic       CLK;
    logic       Clear;
    logic       start;
    logic       dir;
    logic [2:0] amount;
    logic       fill;
    logic [3:0] data_in;
`ifdef ROTATE_EN
    logic       rotate;
`endif
    logic [3:0] a_par;
    logic       s1;
    logic       s0;
    logic       msb_in;
    logic       lsb_in;
    logic [3:0] i_par;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK     (CLK),
        .Clear   (Clear),
        .start   (start),
        .dir     (dir),
        .amount  (amount),
        .fill    (fill),
        .data_in (data_in),
`ifdef ROTATE_EN
        .rotate  (rotate),
`endif
        .a_par   (a_par),
        .s1      (s1),
        .s0      (s0),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .i_par   (i_par),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The controlled universal shift register.
    logic [3:0] sreg = 4'b0000;
    always @(posedge CLK) begin
        case ({s1, s0})
            2'b01:   sreg <= {msb_in, sreg[3:1]};
            2'b10:   sreg <= {sreg[2:0], lsb_in};
            2'b11:   sreg <= i_par;
            default: sreg <= sreg;
        endcase
    end
    assign a_par = sreg;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word after shifting d by n places with fill fl (or rotating when rt).
    function automatic logic [3:0] ref_result(input logic [3:0] d, input logic dr, input int n,
                                              input logic fl, input logic rt);
        logic [7:0] w;
        if (rt) w = dr ? ({d, d} << n) : ({d, d} >> n);
        else    w = dr ? ({d, {4{fl}}} << n) : ({{4{fl}}, d} >> n);
        return dr ? w[7:4] : w[3:0];
    endfunction

    // Expected {s1,s0,msb_in,lsb_in,busy,done} in cycle c after the start edge (c=0: idle).
    function automatic logic [5:0] exp_vec(input int c, input int n, input logic [3:0] d,
                                           input logic dr, input logic fl, input logic rt);
        logic ser;
        if (c == 1) return 6'b11_00_10;
        if (c >= 2 && c <= n + 1) begin
            ser = rt ? (dr ? ref_result(d, dr, c - 2, fl, 1'b1) >> 3
                           : {3'b000, ref_result(d, dr, c - 2, fl, 1'b1)[0]}) : fl;
            return dr ? {4'b10_0_0 | {3'b000, ser}, 2'b10} : {2'b01, ser, 1'b0, 2'b10};
        end
        if (c == n + 2) return 6'b00_00_10;
        if (c == n + 3) return 6'b00_00_11;
        return 6'b0;
    endfunction

    task automatic run_cmd(input logic [3:0] d, input logic dr, input logic [2:0] amt,
                           input logic fl, input logic rt, input logic noisy,
                           input logic [3:0] exp_res);
        int n;
        n = (amt > 3'd4) ? 4 : int'(amt);
        @(negedge CLK);
        data_in = d; dir = dr; amount = amt; fill = fl; start = 1'b1;
`ifdef ROTATE_EN
        rotate = rt;
`endif
        @(negedge CLK);
        check("i_par_latched", 8'(i_par), 8'(d));
        for (int c = 1; c <= n + 3; c++) begin
            check($sformatf("ctrl_cycle%0d", c), 8'({s1, s0, msb_in, lsb_in, busy, done}),
                  8'(exp_vec(c, n, d, dr, fl, rt)));
            if (c == n + 3) check("result", 8'(result), 8'(exp_res));
            if (noisy) begin
                start   = 1'($urandom);
                data_in = 4'($urandom);
                dir     = 1'($urandom);
                amount  = 3'($urandom);
                fill    = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        check("idle_after_done", 8'({s1, s0, msb_in, lsb_in, busy, done}), 8'h00);
        check("result_hold", 8'(result), 8'(exp_res));
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] d;
        logic       dr;
        logic [2:0] amt;
        logic       fl;
        logic       noisy;
        logic [3:0] res;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [3:0] rd;
        logic       rdr;
        logic [2:0] ramt;
        logic       rfl;
        logic       rrt;

        tbl[0] = '{d: 4'b1011, dr: 1'b0, amt: 3'd2, fl: 1'b0, noisy: 1'b0, res: 4'b0010};
        tbl[1] = '{d: 4'b1011, dr: 1'b1, amt: 3'd1, fl: 1'b1, noisy: 1'b0, res: 4'b0111};
        tbl[2] = '{d: 4'b0110, dr: 1'b0, amt: 3'd0, fl: 1'b1, noisy: 1'b0, res: 4'b0110};
        tbl[3] = '{d: 4'b0000, dr: 1'b0, amt: 3'd7, fl: 1'b1, noisy: 1'b1, res: 4'b1111};

        Clear = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; fill = 1'b0; data_in = '0;
`ifdef ROTATE_EN
        rotate = 1'b0;
`endif
        @(negedge CLK);
        Clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("reset_ctrl", 8'({s1, s0, msb_in, lsb_in, busy, done}), 8'h00);
            check("reset_data", 8'({i_par, result}), 8'h00);
        end

        for (int i = 0; i < 4; i++)
            run_cmd(tbl[i].d, tbl[i].dr, tbl[i].amt, tbl[i].fl, 1'b0, tbl[i].noisy, tbl[i].res);

`ifdef ROTATE_EN
        run_cmd(4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 4'b1101);
        run_cmd(4'b1011, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 4'b1011);
`endif

        for (int i = 0; i < 40; i++) begin
            rd = 4'($urandom); rdr = 1'($urandom); ramt = 3'($urandom); rfl = 1'($urandom);
            rrt = 1'b0;
`ifdef ROTATE_EN
            rrt = 1'($urandom);
`endif
            run_cmd(rd, rdr, ramt, rfl, rrt, 1'b1,
                    ref_result(rd, rdr, (ramt > 3'd4) ? 4 : int'(ramt), rfl, rrt));
        end

        // Abort in the second SHIFT cycle: everything clears at once, no done afterwards.
        run_cmd(tbl[1].d, tbl[1].dr, tbl[1].amt, tbl[1].fl, 1'b0, 1'b0, tbl[1].res);
        @(negedge CLK);
        data_in = 4'b1011; dir = 1'b0; amount = 3'd3; fill = 1'b1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_clear_busy", 8'({s1, s0, busy}), 8'b011);
        Clear = 1'b1;
        #1;
        check("clear_ctrl", 8'({s1, s0, msb_in, lsb_in, busy, done}), 8'h00);
        check("clear_data", 8'({i_par, result}), 8'h00);
        @(negedge CLK);
        Clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("post_clear_idle", 8'({s1, s0, msb_in, lsb_in, busy, done}), 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the 4-bit universal shift register (mode selects s1/s0, serial inputs MSB_in/LSB_in, parallel load I_par, parallel output A_par).
- Accepts a start/busy/done command: load a word, shift it N positions left or right with a fill bit, capture the result.
- Sits between a simple command source (bus slave or test FSM) and one shift-register instance. It owns that instance's s1/s0, MSB_in, LSB_in and I_par.

Parameters:
WIDTH, 4, data width; must match the shift register.
CNT_W, 3, width of the shift-amount field.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
Clear  input  1  reset: one clock; reset is asynchronous and active-high.
start  input  1  command request; sampled only in IDLE.
dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
amount  input  CNT_W  number of shift positions.
fill  input  1  serial bit shifted in.
data_in  input  WIDTH  word to load.
a_par  input  WIDTH  parallel output A_par of the controlled register.
s1  output  1  mode select to register.
s0  output  1  mode select to register.
msb_in  output  1  serial input for right shift.
lsb_in  output  1  serial input for left shift.
i_par  output  WIDTH  parallel load data to register.
busy  output  1  high from LOAD through DONE inclusive.
done  output  1  one-cycle completion pulse.
result  output  WIDTH  captured register contents; holds until the next capture.

Behaviour:
- Reset (Clear=1, asynchronous):
  - state=IDLE.
  - s1, s0, msb_in, lsb_in, busy, done = 0; i_par = 0; result = 0.
  - Internal counter and latched command fields = 0.
  - Clear mid-operation aborts immediately; no done pulse.
- Register mode encoding driven on {s1,s0}: 00 hold, 01 shift right (MSB_in enters bit WIDTH-1), 10 shift left (LSB_in enters bit 0), 11 parallel load.
- Effective amount n = min(amount, WIDTH).
- IDLE:
  - {s1,s0}=00, busy=0.
  - start=1 at a rising edge latches data_in into i_par, plus dir, n and fill; next state LOAD.
- LOAD (1 cycle):
  - {s1,s0}=11, busy=1.
  - Next state SHIFT with cnt=n if n>0, else CAPTURE.
- SHIFT (n cycles):
  - {s1,s0}=01 if dir=0, 10 if dir=1.
  - msb_in = fill when dir=0, else 0. lsb_in = fill when dir=1, else 0.
  - cnt decrements each cycle; when cnt==1, next state is CAPTURE.
- CAPTURE (1 cycle):
  - {s1,s0}=00.
  - result <= a_par at the end of the cycle; next state DONE.
- DONE (1 cycle):
  - done=1, {s1,s0}=00, busy=1; next state IDLE.
- Outside SHIFT: msb_in = lsb_in = 0.
- Latency: done is high n+3 cycles after the edge that sampled start. Minimum spacing between commands is n+4 cycles (start may be held high).
- start while busy=1 is ignored and not queued.
- s1/s0/msb_in/lsb_in are decoded from registered state only; no combinational path from the command inputs.

Optional Feature:
ROTATE_EN:
- Defined:
  - Adds input port rotate (1 bit), latched with the command.
  - When the latched rotate=1: msb_in = a_par[0] for right shifts, lsb_in = a_par[WIDTH-1] for left shifts, and fill is ignored.
  - The n clamp still applies, so rotate by WIDTH returns the original word.
- Not defined: port absent; behaviour is exactly as above using fill.

Test Plan:
- Clear pulse, then idle 5 cycles -> all outputs 0, {s1,s0}=00 throughout.
- data_in=1011, dir=0, amount=2, fill=0, start 1 cycle -> {s1,s0} sequence 11,01,01,00,00; done on cycle 5 after start; result=0010.
- data_in=1011, dir=1, amount=1, fill=1 -> result=0111, done 4 cycles after start.
- amount=0, data_in=0110 -> no 01/10 modes driven; result=0110, done 3 cycles after start.
- amount=7, dir=0, fill=1, data_in=0000 -> exactly 4 SHIFT cycles; result=1111; start pulsed during SHIFT has no effect.
- Clear asserted in the 2nd SHIFT cycle -> busy, s1, s0, result = 0 the same cycle; no done. With ROTATE_EN: data_in=1011, dir=0, amount=1, rotate=1 -> result=1101.
